uart_rx_fifo: RTL and testbench

//  Byte FIFO between uart_rx (o_dat/received strobe) and the UART->Wishbone bridge.

---
 rtl/uart_rx_fifo_pkg.sv | 24 ++
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 115 +++++++++++
 tb/tb_uart_rx_fifo.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and push/pop decode for the UART RX byte FIFO.
// Also carries the UART byte width and default FIFO depth shared with the TX-side FIFO.
package uart_rx_fifo_pkg;

  localparam int UART_BYTE_W         = 8;
  localparam int DEF_FIFO_DEPTH_LOG2 = 4;

  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
  } fifo_op_t;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push while draining.
  function automatic fifo_op_t fifo_decode(input logic received, input logic valid,
                                           input logic ready, input logic full);
    fifo_op_t op;
    op.pop  = valid & ready;
    op.push = received & (~full | op.pop);
    op.drop = received & ~op.push;
    return op;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Push side from uart_rx and FWFT valid/ready side toward the Wishbone bridge.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = UART_BYTE_W
);

    logic [WIDTH-1:0] i_dat;
    logic             i_received;
    logic [WIDTH-1:0] o_dat;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output i_dat,
        output i_received,
        output i_ready,
        input  o_dat,
        input  o_valid
    );

    modport slave (
        input  i_dat,
        input  i_received,
        input  i_ready,
        output o_dat,
        output o_valid
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// fifo_mem_2p: un-reset register array, synchronous write, asynchronous read.
module fifo_mem_2p #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdat,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdat
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between uart_rx and the UART->Wishbone bridge; FWFT output, sticky overflow flag.
// Optional RTS hysteresis output enabled with `define UART_RX_FIFO_RTS_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2,
    parameter int WIDTH      = UART_BYTE_W,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    uart_rx_fifo_if.slave         rx,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_overflow,
    input  logic                  i_clr_ovf,
    output logic                  o_rts_n
);

    localparam int              DEPTH   = 1 << DEPTH_LOG2;
    localparam int              CW      = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH_LOG2 must be 2..8");
    end
    if (LOW_WATER >= HIGH_WATER || HIGH_WATER > DEPTH) begin : g_bad_water
        $error("uart_rx_fifo: need LOW_WATER < HIGH_WATER <= depth");
    end

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [WIDTH-1:0]      head_dat;
    fifo_op_t              op;

    // Status is derived only from registered fill level.
    assign rx.o_valid = (count_q != '0);
    assign o_full     = (count_q == DEPTH_C);
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

    assign op = fifo_decode(rx.i_received, rx.o_valid, rx.i_ready, o_full);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (op.push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (op.pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        case ({op.push, op.pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A fresh drop outranks a clear strobe in the same cycle.
        if (op.drop)         ovf_d = 1'b1;
        else if (i_clr_ovf)  ovf_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    fifo_mem_2p #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (op.push),
        .i_waddr (wr_ptr_q),
        .i_wdat  (rx.i_dat),
        .i_raddr (rd_ptr_q),
        .o_rdat  (head_dat)
    );

    assign rx.o_dat = rx.o_valid ? head_dat : '0;

`ifdef UART_RX_FIFO_RTS_EN
    localparam logic [CW-1:0] HW_C = CW'(HIGH_WATER);
    localparam logic [CW-1:0] LW_C = CW'(LOW_WATER);

    logic rts_n_q, rts_n_d;

    // Hysteresis on the post-update fill level; holds between the marks.
    always_comb begin
        rts_n_d = rts_n_q;
        if (count_d >= HW_C)      rts_n_d = 1'b1;
        else if (count_d <= LW_C) rts_n_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) rts_n_q <= 1'b0;
        else         rts_n_q <= rts_n_d;
    end

    assign o_rts_n = rts_n_q;
`else
    assign o_rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH_LOG2=4, WIDTH=8).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [4:0] o_count;
  logic       o_full, o_overflow, i_clr_ovf, o_rts_n;
  int         n_chk = 0;
  int         n_fail = 0;

  uart_rx_fifo_if #(.WIDTH(8)) bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2(4), .WIDTH(8), .HIGH_WATER(12), .LOW_WATER(4)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .rx(bus), .o_count(o_count), .o_full(o_full),
    .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf), .o_rts_n(o_rts_n)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic RTS_EN = 1'b1;
`else
  localparam logic RTS_EN = 1'b0;
`endif

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; bus.i_received = 1'b0; bus.i_ready = 1'b0; bus.i_dat = '0; i_clr_ovf = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    n_chk++; if (o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
    n_chk++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    n_chk++; if (bus.o_dat !== 8'h00) begin n_fail++; $display("FAIL reset_dat got %h want 00", bus.o_dat); end
    n_chk++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", o_full); end
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", o_overflow); end
    n_chk++; if (o_rts_n !== 1'b0) begin n_fail++; $display("FAIL reset_rts got %b want 0", o_rts_n); end
  endtask

  task automatic test_basic();
    bus.i_dat = 8'hA5; bus.i_received = 1'b1; bus.i_ready = 1'b1;
    #1;
    n_chk++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass got %b want 0", bus.o_valid); end
    tick();
    bus.i_received = 1'b0; bus.i_ready = 1'b0;
    n_chk++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.o_valid); end
    n_chk++; if (bus.o_dat !== 8'hA5) begin n_fail++; $display("FAIL basic_dat got %h want a5", bus.o_dat); end
    n_chk++; if (o_count !== 5'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", o_count); end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    n_chk++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid got %b want 0", bus.o_valid); end
    n_chk++; if (o_count !== 5'd0) begin n_fail++; $display("FAIL basic_pop_count got %0d want 0", o_count); end
    n_chk++; if (bus.o_dat !== 8'h00) begin n_fail++; $display("FAIL basic_pop_dat got %h want 00", bus.o_dat); end
  endtask

  task automatic test_overflow();
    logic [7:0] want;
    for (int i = 0; i < 16; i++) begin
      bus.i_dat = 8'(i); bus.i_received = 1'b1; tick();
    end
    bus.i_received = 1'b0;
    n_chk++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", o_full); end
    n_chk++; if (o_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", o_count); end
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b want 0", o_overflow); end
    bus.i_dat = 8'hFF; bus.i_received = 1'b1; tick(); bus.i_received = 1'b0;
    n_chk++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", o_overflow); end
    n_chk++; if (o_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count_after got %0d want 16", o_count); end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      want = 8'(i);
      n_chk++;
      if (bus.o_valid !== 1'b1 || bus.o_dat !== want) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got v=%b d=%h want v=1 d=%h", i, bus.o_valid, bus.o_dat, want);
      end
      tick();
    end
    bus.i_ready = 1'b0;
    n_chk++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_ff_absent got valid=%b want 0", bus.o_valid); end
  endtask

  task automatic test_clr_ovf();
    i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", o_overflow); end
    for (int i = 0; i < 16; i++) begin
      bus.i_dat = 8'(8'h10 + i); bus.i_received = 1'b1; tick();
    end
    bus.i_dat = 8'hEE; i_clr_ovf = 1'b1; tick();
    bus.i_received = 1'b0; i_clr_ovf = 1'b0;
    n_chk++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_drop got %b want 1", o_overflow); end
    n_chk++; if (o_count !== 5'd16) begin n_fail++; $display("FAIL clr_vs_drop_count got %0d want 16", o_count); end
    i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_again got %b want 0", o_overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want;
    bus.i_dat = 8'h55; bus.i_received = 1'b1; bus.i_ready = 1'b1;
    tick();
    bus.i_received = 1'b0; bus.i_ready = 1'b0;
    n_chk++; if (o_count !== 5'd16) begin n_fail++; $display("FAIL fpp_count got %0d want 16", o_count); end
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b want 0", o_overflow); end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      want = (i < 15) ? 8'(8'h11 + i) : 8'h55;
      n_chk++;
      if (bus.o_valid !== 1'b1 || bus.o_dat !== want) begin
        n_fail++; $display("FAIL fpp_drain[%0d] got v=%b d=%h want v=1 d=%h", i, bus.o_valid, bus.o_dat, want);
      end
      tick();
    end
    bus.i_ready = 1'b0;
    n_chk++; if (o_count !== 5'd0) begin n_fail++; $display("FAIL fpp_empty got %0d want 0", o_count); end
  endtask

  task automatic test_interleave();
    logic [7:0] exp_q[$];
    logic [7:0] want;
    int         maxc = 0;
    bus.i_ready = 1'b1;
    for (int cyc = 0; cyc < 42; cyc++) begin
      if (bus.o_valid === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL il_extra got %h want nothing", bus.o_dat);
        end else begin
          want = exp_q.pop_front();
          if (bus.o_dat !== want) begin n_fail++; $display("FAIL il_order got %h want %h", bus.o_dat, want); end
        end
      end
      if (cyc < 40) begin
        bus.i_dat = 8'(8'h40 + cyc); bus.i_received = 1'b1; exp_q.push_back(8'(8'h40 + cyc));
      end else begin
        bus.i_received = 1'b0;
      end
      tick();
      if (int'(o_count) > maxc) maxc = int'(o_count);
    end
    bus.i_ready = 1'b0; bus.i_received = 1'b0;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL il_left got %0d want 0", exp_q.size()); end
    n_chk++; if (maxc > 2) begin n_fail++; $display("FAIL il_maxcount got %0d want <=2", maxc); end
    n_chk++; if (o_count !== 5'd0) begin n_fail++; $display("FAIL il_count got %0d want 0", o_count); end
  endtask

  task automatic test_rts_and_reset();
    for (int i = 0; i < 12; i++) begin
      bus.i_dat = 8'(8'h60 + i); bus.i_received = 1'b1; tick();
      if (i == 10) begin
        n_chk++; if (o_rts_n !== 1'b0) begin n_fail++; $display("FAIL rts_at11 got %b want 0", o_rts_n); end
      end
    end
    bus.i_received = 1'b0;
    n_chk++; if (o_rts_n !== RTS_EN) begin n_fail++; $display("FAIL rts_at12 got %b want %b", o_rts_n, RTS_EN); end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.i_ready = 1'b0;
    n_chk++; if (o_count !== 5'd5) begin n_fail++; $display("FAIL rts_count5 got %0d want 5", o_count); end
    n_chk++; if (o_rts_n !== RTS_EN) begin n_fail++; $display("FAIL rts_at5 got %b want %b", o_rts_n, RTS_EN); end
    bus.i_ready = 1'b1; tick(); bus.i_ready = 1'b0;
    n_chk++; if (o_rts_n !== 1'b0) begin n_fail++; $display("FAIL rts_at4 got %b want 0", o_rts_n); end
    for (int i = 0; i < 3; i++) begin
      bus.i_dat = 8'(8'h70 + i); bus.i_received = 1'b1; tick();
    end
    bus.i_received = 1'b0;
    n_chk++; if (o_count !== 5'd7) begin n_fail++; $display("FAIL rst_pre_count got %0d want 7", o_count); end
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    n_chk++; if (o_count !== 5'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d want 0", o_count); end
    n_chk++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", bus.o_valid); end
    n_chk++; if (bus.o_dat !== 8'h00) begin n_fail++; $display("FAIL rst_mid_dat got %h want 00", bus.o_dat); end
    n_chk++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL rst_mid_full got %b want 0", o_full); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_clr_ovf();
    test_full_push_pop();
    test_interleave();
    test_rts_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
